// File: rtl/pipe_drain_buffer.sv
// Credit-gated receive buffer for a fixed-latency, non-stallable pipeline, drained through a FWFT FIFO.
// Latency: an item captured at edge t is presented on out_data from t+1 (no bypass).
// Backpressure: consumer stalls are absorbed by the FIFO; upstream is throttled via up_ready credits.
module pipe_drain_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             up_ready,
    input  logic             up_launch,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy,
    output logic [CW-1:0]    inflight,
    output logic             err
);

    generate
        if (DEPTH < 1) begin : g_depth_chk
            $error("pipe_drain_buffer: DEPTH must be >= 1");
        end
    endgenerate

    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] inf_q, inf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;

    logic [CW:0] credit_sum;
    logic        launch;
    logic        emerge;
    logic        full;
    logic        read;
    logic        write;

    always_comb begin
        credit_sum = {1'b0, occ_q} + {1'b0, inf_q};
        up_ready   = !rst && (credit_sum < CREDITS);
        out_valid  = (occ_q != '0);
        out_data   = mem_q[rd_ptr_q];
        occupancy  = occ_q;
        inflight   = inf_q;
        err        = err_q;

        launch = up_launch && up_ready;
        emerge = pipe_valid && (inf_q != '0);
        full   = (occ_q == FULL_OCC);
        read   = out_valid && out_ready;
        // At full, a same-cycle read frees the head slot, which is also the write slot.
        write  = emerge && (!full || read);
    end

    always_comb begin
        inf_d    = inf_q + CW'(launch) - CW'(emerge);
        occ_d    = occ_q + CW'(write) - CW'(read);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (read) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        err_d = err_q
              | (up_launch && !up_ready)
              | (pipe_valid && (inf_q == '0))
              | (pipe_valid && full && !read);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= '0;
            inf_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            inf_q    <= inf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Directed bench: DEPTH=8 and DEPTH=5 instances, each fed by a 4-stage delay line.
module tb_pipe_drain_buffer;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Instance A: DEPTH=8
    logic        a_up_ready, a_up_launch = 1'b0, a_pipe_valid, a_out_valid, a_out_ready = 1'b0, a_err;
    logic        a_inj_vld = 1'b0;
    logic [31:0] a_up_dat = '0, a_inj_dat = '0, a_pipe_data, a_out_data;
    logic [3:0]  a_occ, a_inf;
    logic        a_sv [LAT];
    logic [31:0] a_sd [LAT];

    always @(posedge clk) begin
        a_sv[0] <= a_up_launch && a_up_ready;
        a_sd[0] <= a_up_dat;
        for (int i = 1; i < LAT; i++) begin
            a_sv[i] <= a_sv[i-1];
            a_sd[i] <= a_sd[i-1];
        end
    end
    assign a_pipe_valid = a_sv[LAT-1] | a_inj_vld;
    assign a_pipe_data  = a_inj_vld ? a_inj_dat : a_sd[LAT-1];

    pipe_drain_buffer #(.WIDTH(32), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst), .up_ready(a_up_ready), .up_launch(a_up_launch),
        .pipe_valid(a_pipe_valid), .pipe_data(a_pipe_data), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_ready(a_out_ready), .occupancy(a_occ),
        .inflight(a_inf), .err(a_err)
    );

    // Instance B: DEPTH=5
    logic        b_up_ready, b_up_launch = 1'b0, b_pipe_valid, b_out_valid, b_out_ready = 1'b0, b_err;
    logic [31:0] b_up_dat = '0, b_pipe_data, b_out_data;
    logic [2:0]  b_occ, b_inf;
    logic        b_sv [LAT];
    logic [31:0] b_sd [LAT];

    always @(posedge clk) begin
        b_sv[0] <= b_up_launch && b_up_ready;
        b_sd[0] <= b_up_dat;
        for (int i = 1; i < LAT; i++) begin
            b_sv[i] <= b_sv[i-1];
            b_sd[i] <= b_sd[i-1];
        end
    end
    assign b_pipe_valid = b_sv[LAT-1];
    assign b_pipe_data  = b_sd[LAT-1];

    pipe_drain_buffer #(.WIDTH(32), .DEPTH(5)) u_b (
        .clk(clk), .rst(rst), .up_ready(b_up_ready), .up_launch(b_up_launch),
        .pipe_valid(b_pipe_valid), .pipe_data(b_pipe_data), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_ready(b_out_ready), .occupancy(b_occ),
        .inflight(b_inf), .err(b_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got, bubbles, k, max_sum, sum;
        bit started;
        logic [31:0] exp_q [$];
        logic [31:0] exp_v;

        // 1: reset state, then idle
        repeat (5) @(negedge clk);
        check_eq("rst_up_ready", 32'(a_up_ready), 0);
        check_eq("rst_out_valid", 32'(a_out_valid), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_up_ready", 32'(a_up_ready), 1);
        check_eq("idle_out_valid", 32'(a_out_valid), 0);
        check_eq("idle_occ", 32'(a_occ), 0);
        check_eq("idle_inf", 32'(a_inf), 0);
        check_eq("idle_err", 32'(a_err), 0);

        // 2: full-rate streaming 0..99
        a_out_ready = 1'b1;
        n = 0; got = 0; bubbles = 0; started = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
            if (a_out_valid) begin
                check_eq("t2_data", a_out_data, 32'(got));
                got++;
                started = 1'b1;
            end else if (started) begin
                bubbles++;
            end
            if (a_up_ready && n < 100) begin
                a_up_launch = 1'b1;
                a_up_dat    = 32'(n);
                n++;
            end else begin
                a_up_launch = 1'b0;
            end
            @(negedge clk);
        end
        a_up_launch = 1'b0;
        check_eq("t2_count", 32'(got), 100);
        check_eq("t2_bubbles", 32'(bubbles), 0);
        check_eq("t2_err", 32'(a_err), 0);

        // 3: stalled consumer fills credits, then drain
        a_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (!a_up_ready) break;
            a_up_launch = 1'b1;
            a_up_dat    = 32'(200 + k);
            k++;
            @(negedge clk);
        end
        a_up_launch = 1'b0;
        check_eq("t3_launches", 32'(k), 8);
        repeat (6) @(negedge clk);
        check_eq("t3_occ_full", 32'(a_occ), 8);
        check_eq("t3_inf_zero", 32'(a_inf), 0);
        check_eq("t3_up_ready_low", 32'(a_up_ready), 0);
        check_eq("t3_head", a_out_data, 200);
        check_eq("t3_err", 32'(a_err), 0);
        @(negedge clk);
        check_eq("t3_head_stable", a_out_data, 200);
        check_eq("t3_valid_hold", 32'(a_out_valid), 1);

        // 4b: launch attempt without credit
        a_up_launch = 1'b1;
        @(negedge clk);
        a_up_launch = 1'b0;
        check_eq("t4_launch_err", 32'(a_err), 1);
        check_eq("t4_launch_inf", 32'(a_inf), 0);
        check_eq("t4_launch_occ", 32'(a_occ), 8);

        a_out_ready = 1'b1;
        #1;
        check_eq("t3_no_comb_ready", 32'(a_up_ready), 0);
        for (int j = 1; j < 8; j++) begin
            @(negedge clk);
            check_eq("t3_drain_valid", 32'(a_out_valid), 1);
            check_eq("t3_drain_data", a_out_data, 32'(200 + j));
            if (j == 1) check_eq("t3_credit_return", 32'(a_up_ready), 1);
        end
        @(negedge clk);
        check_eq("t3_empty_occ", 32'(a_occ), 0);
        check_eq("t3_empty_valid", 32'(a_out_valid), 0);
        a_out_ready = 1'b0;

        // 4a: orphan pipe_valid with nothing in flight
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t4_err_clear", 32'(a_err), 0);
        a_inj_dat = 32'd55;
        a_inj_vld = 1'b1;
        @(negedge clk);
        a_inj_vld = 1'b0;
        check_eq("t4_orphan_err", 32'(a_err), 1);
        check_eq("t4_orphan_occ", 32'(a_occ), 0);
        check_eq("t4_orphan_valid", 32'(a_out_valid), 0);
        repeat (3) @(negedge clk);
        check_eq("t4_err_sticky", 32'(a_err), 1);

        // 5: DEPTH=5, random 30% consumer, 1000 items
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = 0; got = 0; max_sum = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            sum = int'(b_occ) + int'(b_inf);
            if (sum > max_sum) max_sum = sum;
            b_out_ready = ($urandom_range(0, 99) < 30);
            if (b_out_valid && b_out_ready) begin
                check_eq("t5_sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("t5_order", b_out_data, exp_v);
                end
                got++;
            end
            if (b_up_ready && n < 1000) begin
                b_up_launch = 1'b1;
                b_up_dat    = $urandom;
                exp_q.push_back(b_up_dat);
                n++;
            end else begin
                b_up_launch = 1'b0;
            end
            @(negedge clk);
        end
        b_up_launch = 1'b0;
        b_out_ready = 1'b0;
        check_eq("t5_count", 32'(got), 1000);
        check_eq("t5_credit_bound", 32'(max_sum > 5), 0);
        check_eq("t5_credit_reached", 32'(max_sum), 5);
        check_eq("t5_err", 32'(b_err), 0);
        check_eq("t5_occ_end", 32'(b_occ), 0);
        check_eq("t5_inf_end", 32'(b_inf), 0);

        // 6: reset with occupancy=3, inflight=2
        a_out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            a_up_launch = 1'b1;
            a_up_dat    = 32'(300 + i);
            @(negedge clk);
        end
        a_up_launch = 1'b0;
        for (int c = 0; c < 10 && a_occ != 4'd3; c++) @(negedge clk);
        check_eq("t6_pre_occ", 32'(a_occ), 3);
        check_eq("t6_pre_inf", 32'(a_inf), 2);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_occ", 32'(a_occ), 0);
        check_eq("t6_rst_inf", 32'(a_inf), 0);
        check_eq("t6_rst_valid", 32'(a_out_valid), 0);
        check_eq("t6_rst_up_ready", 32'(a_up_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t6_rel_up_ready", 32'(a_up_ready), 1);
        check_eq("t6_rel_err", 32'(a_err), 0);
        repeat (4) @(negedge clk);
        check_eq("t6_stale_err", 32'(a_err), 1);
        check_eq("t6_stale_occ", 32'(a_occ), 0);
        check_eq("t6_stale_inf", 32'(a_inf), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
